// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision add/sub back end.
package fp_pkg;

   localparam int unsigned EXP_BIAS  = 127;
   localparam logic [7:0]  EXP_MAX   = 8'hFF;
   localparam int unsigned MAN_W     = 23;
   localparam logic [22:0] QNAN_FRAC = 23'h400000;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized or denormal mantissa using guard/round/sticky.
module fp_round_rne #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic [MAN_W:0] i_man,
   input  logic [2:0]     i_grs,
   input  logic [EXP_W:0] i_exp,
   output logic [MAN_W:0] o_man,
   output logic [EXP_W:0] o_exp,
   output logic           o_inexact
);

   localparam logic [EXP_W:0] L_EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

   logic           w_up;
   logic [MAN_W+1:0] w_sum;

   always_comb begin
      w_up      = i_grs[2] & (i_grs[1] | i_grs[0] | i_man[0]);
      w_sum     = {1'b0, i_man} + {{(MAN_W+1){1'b0}}, w_up};
      o_man     = w_sum[MAN_W:0];
      o_exp     = i_exp;
      o_inexact = |i_grs;
      // A carry out only occurs from all-ones, so the dropped LSB is always zero.
      if (w_sum[MAN_W+1]) begin
         o_man = w_sum[MAN_W+1:1];
         o_exp = i_exp + L_EXP_ONE;
      end else if ((i_exp == '0) && w_sum[MAN_W]) begin
         o_exp = L_EXP_ONE;
      end
   end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalize, round (RNE) and pack an add/sub result into an IEEE-754 single word.
module fp_normalize_pack #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_W-1:0]       in_exp,
   input  logic [MAN_W+1:0]       in_man,
   input  logic [2:0]             in_grs,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   zero,
   output logic                   inexact
);

   import fp_pkg::*;

   localparam logic [EXP_W:0]   L_EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
   localparam logic [EXP_W:0]   L_EXP_INF = {1'b0, {EXP_W{1'b1}}};
   localparam logic [MAN_W-1:0] L_QNAN    = {1'b1, {(MAN_W-1){1'b0}}};

   state_t               r_state, w_state_nxt;
   logic                 r_sign, w_sign_nxt;
   logic [EXP_W:0]       r_exp, w_exp_nxt;
   logic [MAN_W+1:0]     r_man, w_man_nxt;
   logic [2:0]           r_grs, w_grs_nxt;
   logic [EXP_W+MAN_W:0] r_result, w_result_nxt;
   logic                 r_ovf, w_ovf_nxt;
   logic                 r_unf, w_unf_nxt;
   logic                 r_zero, w_zero_nxt;
   logic                 r_inx, w_inx_nxt;

   logic [MAN_W:0]       w_rnd_man;
   logic [EXP_W:0]       w_rnd_exp;
   logic                 w_rnd_inexact;
   logic                 w_unused_hidden;

   fp_round_rne #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .i_man     (r_man[MAN_W:0]),
      .i_grs     (r_grs),
      .i_exp     (r_exp),
      .o_man     (w_rnd_man),
      .o_exp     (w_rnd_exp),
      .o_inexact (w_rnd_inexact)
   );

   assign w_unused_hidden = w_rnd_man[MAN_W];
   assign in_ready        = (r_state == IDLE) & rst;
   assign out_valid       = (r_state == DONE);
   assign result          = r_result;
   assign overflow        = r_ovf;
   assign underflow       = r_unf;
   assign zero            = r_zero;
   assign inexact         = r_inx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_man    <= '0;
         r_grs    <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_zero   <= 1'b0;
         r_inx    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sign   <= w_sign_nxt;
         r_exp    <= w_exp_nxt;
         r_man    <= w_man_nxt;
         r_grs    <= w_grs_nxt;
         r_result <= w_result_nxt;
         r_ovf    <= w_ovf_nxt;
         r_unf    <= w_unf_nxt;
         r_zero   <= w_zero_nxt;
         r_inx    <= w_inx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sign_nxt   = r_sign;
      w_exp_nxt    = r_exp;
      w_man_nxt    = r_man;
      w_grs_nxt    = r_grs;
      w_result_nxt = r_result;
      w_ovf_nxt    = r_ovf;
      w_unf_nxt    = r_unf;
      w_zero_nxt   = r_zero;
      w_inx_nxt    = r_inx;

      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_sign_nxt  = in_sign;
               w_exp_nxt   = {1'b0, in_exp};
               w_man_nxt   = in_man;
               w_grs_nxt   = in_grs;
               w_state_nxt = NORM;
            end
         end

         NORM: begin
            if ((r_man == '0) && (r_grs == '0)) begin
               w_result_nxt = '0;
               w_ovf_nxt    = 1'b0;
               w_unf_nxt    = 1'b0;
               w_zero_nxt   = 1'b1;
               w_inx_nxt    = 1'b0;
               w_state_nxt  = DONE;
            end else if (r_exp == L_EXP_INF) begin
               w_result_nxt = {r_sign, {EXP_W{1'b1}},
                               (r_man[MAN_W-1:0] == '0) ? {MAN_W{1'b0}} : L_QNAN};
               w_ovf_nxt    = 1'b0;
               w_unf_nxt    = 1'b0;
               w_zero_nxt   = 1'b0;
               w_inx_nxt    = 1'b0;
               w_state_nxt  = DONE;
            end else if (r_man[MAN_W+1]) begin
               w_man_nxt   = {1'b0, r_man[MAN_W+1:1]};
               w_grs_nxt   = {r_man[0], r_grs[2], r_grs[1] | r_grs[0]};
               w_exp_nxt   = r_exp + L_EXP_ONE;
               w_state_nxt = ROUND;
            end else if (!r_man[MAN_W]) begin
               // One bit per cycle; the exponent floor of 1 maps onto the denormal encoding.
               if (r_exp > L_EXP_ONE) begin
                  w_man_nxt = {r_man[MAN_W:0], r_grs[2]};
                  w_grs_nxt = {r_grs[1], r_grs[0], 1'b0};
                  w_exp_nxt = r_exp - L_EXP_ONE;
               end else begin
                  w_exp_nxt   = '0;
                  w_state_nxt = ROUND;
               end
            end else begin
               w_state_nxt = ROUND;
            end
         end

         ROUND: begin
            if (w_rnd_exp >= L_EXP_INF) begin
               w_result_nxt = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               w_ovf_nxt    = 1'b1;
            end else begin
               w_result_nxt = {r_sign, w_rnd_exp[EXP_W-1:0], w_rnd_man[MAN_W-1:0]};
               w_ovf_nxt    = 1'b0;
            end
            w_inx_nxt   = w_rnd_inexact;
            w_unf_nxt   = w_rnd_inexact & (w_rnd_exp == '0);
            w_zero_nxt  = 1'b0;
            w_state_nxt = DONE;
         end

         DONE: begin
            if (out_ready) w_state_nxt = IDLE;
         end

         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Randomized and directed bench for fp_normalize_pack against an integer-arithmetic model.
module tb_fp_normalize_pack;

   typedef struct packed {
      logic [31:0] res;
      logic        ov;
      logic        un;
      logic        z;
      logic        ix;
      logic        special;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_man;
   logic [2:0]  in_grs;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        zero;
   logic        inexact;

   int   n_checks;
   int   n_fail;
   exp_t ex;
   logic exp_pending;

   fp_normalize_pack #(
      .EXP_W (8),
      .MAN_W (23)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_man    (in_man),
      .in_grs    (in_grs),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .zero      (zero),
      .inexact   (inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Treats {man,grs} as one fixed-point integer with three fractional bits.
   function automatic exp_t model(input logic s, input logic [7:0] e_in,
                                  input logic [24:0] m, input logic [2:0] g);
      exp_t   r;
      longint v;
      longint keep;
      longint rem;
      int     e;
      r = '0;
      v = longint'({m, g});
      e = int'(e_in);
      if (v == 0) begin
         r.z       = 1'b1;
         r.special = 1'b1;
         return r;
      end
      if (e == 255) begin
         r.res     = {s, 8'hFF, (m[22:0] == 23'h0) ? 23'h0 : 23'h400000};
         r.special = 1'b1;
         return r;
      end
      if (v >= (longint'(1) << 27)) begin
         v = (v >> 1) | (v & 1);
         e = e + 1;
      end else begin
         while (v < (longint'(1) << 26) && e > 1) begin
            v     = v << 1;
            e     = e - 1;
            r.lat = r.lat + 1;
         end
         if (v < (longint'(1) << 26)) e = 0;
      end
      r.lat = r.lat + 2;
      keep  = v >> 3;
      rem   = v & 7;
      if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
      if (keep == (longint'(1) << 24)) begin
         keep = keep >> 1;
         e    = e + 1;
      end
      if (e == 0 && keep >= (longint'(1) << 23)) e = 1;
      r.ix = (rem != 0);
      if (e >= 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.ov  = 1'b1;
      end else begin
         r.res = {s, 8'(e), 23'(keep)};
      end
      r.un = r.ix && (e == 0);
      return r;
   endfunction

   task automatic pin(input string name, input logic s, input logic [7:0] e,
                      input logic [24:0] m, input logic [2:0] g,
                      input logic [31:0] res, input logic [3:0] flags, input int lat);
      exp_t p;
      p = model(s, e, m, g);
      chk({name, "_res"}, p.res, res);
      chk({name, "_flags"}, 32'({p.ov, p.un, p.z, p.ix}), 32'(flags));
      if (lat >= 0) chk({name, "_lat"}, 32'(p.lat), 32'(lat));
   endtask

   task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                         input logic [2:0] g, input int hold);
      int t;
      ex = model(s, e, m, g);
      t  = 0;
      while (!in_ready && t < 64) begin
         @(posedge clk); #1;
         t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_sign  = s;
      in_exp   = e;
      in_man   = m;
      in_grs   = g;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      exp_pending = 1'b1;
      t = 0;
      while (!out_valid && t < 64) begin
         @(posedge clk); #1;
         t++;
      end
      chk("out_valid_seen", 32'(out_valid), 32'd1);
      if (ex.special) chk("latency_special", 32'(t == 1 || t == 2), 32'd1);
      else            chk("latency", 32'(t), 32'(ex.lat));
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready   = 1'b0;
      exp_pending = 1'b0;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_after", 32'(in_ready), 32'd1);
   endtask

   // Every cycle the result is presented it must match the model and hold steady.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         chk("valid_expected", 32'(exp_pending), 32'd1);
         chk("result", result, ex.res);
         chk("flags", 32'({overflow, underflow, zero, inexact}), 32'({ex.ov, ex.un, ex.z, ex.ix}));
         chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] r32;
      logic [31:0] mask;
      logic [24:0] rm;
      logic [7:0]  re;
      int          w;
      int          sel;
      n_checks    = 0;
      n_fail      = 0;
      exp_pending = 1'b0;
      ex          = '0;
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_sign     = 1'b0;
      in_exp      = '0;
      in_man      = '0;
      in_grs      = '0;
      out_ready   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", 32'({overflow, underflow, zero, inexact}), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      pin("t1",   1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 4'b0000, 2);
      pin("t2",   1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 4'b0000, 25);
      pin("t3a",  1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 4'b0001, 2);
      pin("t3b",  1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 4'b0001, 2);
      pin("t4",   1'b0, 8'd254, 25'h1FFFFFF, 3'b111, 32'h7F800000, 4'b1001, 2);
      pin("t5a",  1'b0, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 4'b0010, -1);
      pin("t5b",  1'b0, 8'd1,   25'h0400000, 3'b000, 32'h00400000, 4'b0000, 2);
      pin("nan",  1'b1, 8'd255, 25'h0000001, 3'b000, 32'hFFC00000, 4'b0000, -1);
      pin("inf",  1'b1, 8'd255, 25'h0800000, 3'b000, 32'hFF800000, 4'b0000, -1);
      pin("unf",  1'b0, 8'd1,   25'h0000001, 3'b001, 32'h00000001, 4'b0101, 2);
      pin("nzro", 1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 4'b0010, -1);

      run_op(1'b0, 8'd127, 25'h1000000, 3'b000, 5);
      run_op(1'b0, 8'd127, 25'h0000001, 3'b000, 0);
      run_op(1'b0, 8'd127, 25'h0800001, 3'b100, 1);
      run_op(1'b0, 8'd127, 25'h0800000, 3'b100, 0);
      run_op(1'b0, 8'd254, 25'h1FFFFFF, 3'b111, 2);
      run_op(1'b0, 8'd127, 25'h0000000, 3'b000, 0);
      run_op(1'b0, 8'd1,   25'h0400000, 3'b000, 0);
      run_op(1'b1, 8'd255, 25'h0000001, 3'b000, 0);
      run_op(1'b1, 8'd255, 25'h0800000, 3'b000, 0);
      run_op(1'b0, 8'd1,   25'h0000001, 3'b001, 0);
      run_op(1'b1, 8'd100, 25'h0000000, 3'b000, 0);

      // Abort a long normalization with reset; nothing may surface afterwards.
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_man   = 25'h0000001;
      in_grs   = 3'b000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("norm_busy_in_ready", 32'(in_ready), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_result", result, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (30) begin
         @(posedge clk); #1;
      end
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      run_op(1'b0, 8'd127, 25'h0000001, 3'b000, 0);

      for (int i = 0; i < 150; i++) begin
         w    = $urandom_range(0, 25);
         r32  = $urandom;
         mask = (32'h1 << w) - 32'h1;
         rm   = r32[24:0] & mask[24:0];
         sel  = $urandom_range(0, 9);
         if (sel == 0)      re = 8'd255;
         else if (sel == 1) re = 8'($urandom_range(1, 3));
         else if (sel == 2) re = 8'($urandom_range(250, 254));
         else               re = 8'($urandom_range(1, 254));
         run_op(1'($urandom_range(0, 1)), re, rm, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
